alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64, power of two).
REQ-002 SHALL have parameter MUL_EN, default 1, enables the iterative multiply (1) or treats mult as illegal (0).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port alu_op  input  2  main-decoder class: 00 add, 01 sub, 10 R-type (use funct), 11 reserved.
REQ-008 SHALL have port funct  input  6  R-type function field.
REQ-009 SHALL have port src_a  input  WIDTH  operand A.
REQ-010 SHALL have port src_b  input  WIDTH  operand B.
REQ-011 SHALL have port shamt  input  $clog2(WIDTH)  shift amount for sll/srl.
REQ-012 SHALL have port out_valid  output  1  result register holds an unconsumed result.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result this cycle.
REQ-014 SHALL have port result  output  WIDTH  registered result.
REQ-015 SHALL have port zero  output  1  registered, result == 0.
REQ-016 SHALL have port alu_ctrl  output  4  registered decoded control code of the held result.
REQ-017 SHALL have port illegal  output  1  registered, held result came from an undecodable op.
REQ-018 SHALL have port busy  output  1  multiply in progress.

Function
REQ-019 Decode SHALL be: alu_op 00 -> 0010 add; 01 -> 0110 sub; 10 with funct 100000 add 0010, 100010 sub 0110, 100100 and 0000, 100101 or 0001, 100110 xor 0011, 100111 nor 1100, 101010 slt 0111, 000000 sll 1000, 000010 srl 1001, 011000 mult 1010 (MUL_EN=1 only).
REQ-020 Any other alu_op/funct combination (incl. alu_op 11, mult with MUL_EN=0) SHALL decode to alu_ctrl 1111, result 0, zero 1, illegal 1; single-cycle latency.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; overflow ignored, no trap.
REQ-022 slt SHALL compare signed two's-complement, result 1 or 0 zero-extended to WIDTH.
REQ-023 sll/srl SHALL shift src_b by shamt, zero fill (logical).
REQ-024 mult SHALL return the low WIDTH bits of the unsigned product src_a*src_b.
REQ-025 in_ready SHALL equal !busy && (!out_valid || out_ready), combinational.
REQ-026 A request is accepted on a rising edge with in_valid && in_ready; no other request is captured.
REQ-027 Single-cycle ops SHALL load result, zero, alu_ctrl, illegal and set out_valid on the accepting edge (latency 1).
REQ-028 mult SHALL, on the accepting edge, latch operands, load iteration counter with WIDTH, set busy, leave out_valid 0.
REQ-029 mult SHALL perform one shift-add iteration per subsequent edge; on the WIDTH-th iteration edge it SHALL load the product into result, set out_valid, clear busy (out_valid rises WIDTH edges after acceptance).
REQ-030 out_valid && out_ready on an edge with no new acceptance SHALL clear out_valid; held outputs keep their last values.
REQ-031 Consumption and new acceptance on the same edge SHALL overwrite the output register with the new single-cycle result, out_valid stays 1 (full throughput).
REQ-032 While out_valid && !out_ready, result/zero/alu_ctrl/illegal SHALL remain stable.
REQ-033 Input changes while busy SHALL not affect the multiply in progress.

Reset
REQ-034 rst_n low SHALL immediately clear out_valid, busy, result, zero, illegal, alu_ctrl to 0 and counter to 0, aborting any multiply.
REQ-035 After rst_n deasserts, in_ready SHALL be 1 on the first cycle.

Verification
REQ-036 alu_op 10, funct 100010, A=5, B=7, WIDTH 32 -> next edge result 0xFFFFFFFE, alu_ctrl 0110, zero 0, out_valid 1.
REQ-037 alu_op 10, funct 101010, A=0xFFFFFFFF, B=1 -> result 1; A=1, B=0xFFFFFFFF -> result 0, zero 1.
REQ-038 mult A=12, B=13, out_ready 1 -> busy for 32 cycles, in_ready 0, then result 156, alu_ctrl 1010, out_valid exactly 32 edges after acceptance.
REQ-039 Back-to-back adds with out_ready toggling 1/0 -> every accepted op appears once, in order, none lost or duplicated, outputs stable while stalled.
REQ-040 alu_op 11 and funct 111111 -> alu_ctrl 1111, illegal 1, result 0; with MUL_EN=0 funct 011000 -> illegal 1, no busy.
REQ-041 rst_n pulsed low at iteration 10 of a mult -> busy 0, out_valid 0 immediately; no stale product ever emitted.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ALU execution unit: decodes alu_op/funct, computes single-cycle results into a
// valid/ready output register, and runs an iterative shift-add multiply.
module alu_exec_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MUL_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic [5:0]               funct,
  input  logic [WIDTH-1:0]         src_a,
  input  logic [WIDTH-1:0]         src_b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     zero,
  output logic [3:0]               alu_ctrl,
  output logic                     illegal,
  output logic                     busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [3:0] {
    CtrlAnd = 4'b0000,
    CtrlOr  = 4'b0001,
    CtrlAdd = 4'b0010,
    CtrlXor = 4'b0011,
    CtrlSub = 4'b0110,
    CtrlSlt = 4'b0111,
    CtrlSll = 4'b1000,
    CtrlSrl = 4'b1001,
    CtrlMul = 4'b1010,
    CtrlNor = 4'b1100,
    CtrlIll = 4'b1111
  } ctrl_e;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e            state_q, state_d;
  ctrl_e             ctrl_q, ctrl_d;
  logic              out_valid_q, out_valid_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  mul_a_q, mul_a_d;
  logic [WIDTH-1:0]  mul_b_q, mul_b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  ctrl_e             dec_ctrl;
  logic [WIDTH-1:0]  alu_res;
  logic [WIDTH-1:0]  mul_step;
  logic              accept;

  always_comb begin
    dec_ctrl = CtrlIll;
    case (alu_op)
      2'b00: dec_ctrl = CtrlAdd;
      2'b01: dec_ctrl = CtrlSub;
      2'b10: begin
        case (funct)
          6'b100000: dec_ctrl = CtrlAdd;
          6'b100010: dec_ctrl = CtrlSub;
          6'b100100: dec_ctrl = CtrlAnd;
          6'b100101: dec_ctrl = CtrlOr;
          6'b100110: dec_ctrl = CtrlXor;
          6'b100111: dec_ctrl = CtrlNor;
          6'b101010: dec_ctrl = CtrlSlt;
          6'b000000: dec_ctrl = CtrlSll;
          6'b000010: dec_ctrl = CtrlSrl;
          6'b011000: dec_ctrl = (MUL_EN != 0) ? CtrlMul : CtrlIll;
          default:   dec_ctrl = CtrlIll;
        endcase
      end
      default: dec_ctrl = CtrlIll;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      CtrlAdd: alu_res = src_a + src_b;
      CtrlSub: alu_res = src_a - src_b;
      CtrlAnd: alu_res = src_a & src_b;
      CtrlOr:  alu_res = src_a | src_b;
      CtrlXor: alu_res = src_a ^ src_b;
      CtrlNor: alu_res = ~(src_a | src_b);
      CtrlSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      CtrlSll: alu_res = src_b << shamt;
      CtrlSrl: alu_res = src_b >> shamt;
      default: alu_res = '0;
    endcase
  end

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    out_valid_d = out_valid_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    result_d    = result_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mul_step    = acc_q + (mul_b_q[0] ? mul_a_q : '0);

    if (state_q == StMul) begin
      acc_d   = mul_step;
      mul_a_d = mul_a_q << 1;
      mul_b_d = mul_b_q >> 1;
      cnt_d   = cnt_q - CntW'(1);
      // Last iteration: the partial sum computed this cycle is the full product.
      if (cnt_q == CntW'(1)) begin
        state_d     = StIdle;
        result_d    = mul_step;
        zero_d      = (mul_step == '0);
        ctrl_d      = CtrlMul;
        illegal_d   = 1'b0;
        out_valid_d = 1'b1;
      end
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (accept) begin
        if (dec_ctrl == CtrlMul) begin
          state_d     = StMul;
          mul_a_d     = src_a;
          mul_b_d     = src_b;
          acc_d       = '0;
          cnt_d       = CntW'(WIDTH);
          out_valid_d = 1'b0;
        end else begin
          result_d    = alu_res;
          zero_d      = (alu_res == '0);
          ctrl_d      = dec_ctrl;
          illegal_d   = (dec_ctrl == CtrlIll);
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ctrl_q      <= CtrlAnd;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      result_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      result_q    <= result_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign alu_ctrl  = ctrl_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q == StMul);

endmodule
